alu_operand_fetch: RTL and testbench

Operand-read stage of the SIMD/SALU pipeline, directly downstream of the issue→ALU pipeline flops. It captures one issued ALU instruction, reads up to two source operands from the register file over a shared single read port, and then presents the complete instruction with its operands to the execute stage under a valid/ready handshake. While an instruction is in flight it holds `busy` high so that issue does not select the ALU.

---
 rtl/alu_operand_fetch.sv | 179 +++++++++++++++++
 tb/tb_alu_operand_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_fetch.sv
// Operand-read stage between issue and ALU execute: latches one instruction,
// fetches up to two operands over a shared RF read port, hands off to execute.
module alu_operand_fetch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_alu_select,
    input  logic [5:0]        issue_wfid,
    input  logic [31:0]       issue_instr_pc,
    input  logic [31:0]       issue_opcode,
    input  logic [15:0]       issue_imm_value0,
    input  logic [31:0]       issue_imm_value1,
    input  logic [11:0]       issue_src1_addr,
    input  logic [11:0]       issue_src2_addr,
    input  logic [11:0]       issue_dest1_addr,
    input  logic [11:0]       issue_dest2_addr,
    output logic              busy,
    output logic              err_overrun,
    output logic              rf_rd_en,
    output logic              rf_rd_is_vgpr,
    output logic [9:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              exec_valid,
    input  logic              exec_ready,
    output logic [5:0]        exec_wfid,
    output logic [31:0]       exec_instr_pc,
    output logic [31:0]       exec_opcode,
    output logic [15:0]       exec_imm_value0,
    output logic [11:0]       exec_dest1_addr,
    output logic [11:0]       exec_dest2_addr,
    output logic [DATA_W-1:0] exec_src1_data,
    output logic [DATA_W-1:0] exec_src2_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        CAP2,
        VALID
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        wfid_q, wfid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       opcode_q, opcode_d;
    logic [15:0]       imm0_q, imm0_d;
    logic [31:0]       imm1_q, imm1_d;
    logic [11:0]       src1_addr_q, src1_addr_d;
    logic [11:0]       src2_addr_q, src2_addr_d;
    logic [11:0]       dest1_q, dest1_d;
    logic [11:0]       dest2_q, dest2_d;
    logic [DATA_W-1:0] src1_data_q, src1_data_d;
    logic [DATA_W-1:0] src2_data_q, src2_data_d;
    logic              err_q, err_d;
    logic              accept;
    logic [DATA_W-1:0] literal;

    function automatic logic is_lit(input logic [11:0] a);
        return a[11:10] == 2'b00;
    endfunction

    // SGPR space is 512 entries, so bit 9 is not part of its index
    function automatic logic [9:0] rf_index(input logic [11:0] a);
        return a[11] ? a[9:0] : {1'b0, a[8:0]};
    endfunction

    assign literal = DATA_W'(imm1_q);

    always_comb begin
        state_d       = state_q;
        wfid_d        = wfid_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        imm0_d        = imm0_q;
        imm1_d        = imm1_q;
        src1_addr_d   = src1_addr_q;
        src2_addr_d   = src2_addr_q;
        dest1_d       = dest1_q;
        dest2_d       = dest2_q;
        src1_data_d   = src1_data_q;
        src2_data_d   = src2_data_q;
        rf_rd_en      = 1'b0;
        rf_rd_is_vgpr = 1'b0;
        rf_rd_addr    = '0;

        busy   = (state_q != IDLE) && !(state_q == VALID && exec_ready);
        accept = issue_alu_select && !busy;
        err_d  = err_q | (issue_alu_select & busy);

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = RD1;
            end
            RD1: begin
                if (!is_lit(src1_addr_q)) begin
                    rf_rd_en      = 1'b1;
                    rf_rd_is_vgpr = src1_addr_q[11];
                    rf_rd_addr    = rf_index(src1_addr_q);
                end
                state_d = RD2;
            end
            RD2: begin
                src1_data_d = is_lit(src1_addr_q) ? literal : rf_rd_data;
                if (!is_lit(src2_addr_q)) begin
                    rf_rd_en      = 1'b1;
                    rf_rd_is_vgpr = src2_addr_q[11];
                    rf_rd_addr    = rf_index(src2_addr_q);
                end
                state_d = CAP2;
            end
            CAP2: begin
                src2_data_d = is_lit(src2_addr_q) ? literal : rf_rd_data;
                state_d     = VALID;
            end
            VALID: begin
                if (exec_ready) state_d = accept ? RD1 : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            wfid_d      = issue_wfid;
            pc_d        = issue_instr_pc;
            opcode_d    = issue_opcode;
            imm0_d      = issue_imm_value0;
            imm1_d      = issue_imm_value1;
            src1_addr_d = issue_src1_addr;
            src2_addr_d = issue_src2_addr;
            dest1_d     = issue_dest1_addr;
            dest2_d     = issue_dest2_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wfid_q      <= '0;
            pc_q        <= '0;
            opcode_q    <= '0;
            imm0_q      <= '0;
            imm1_q      <= '0;
            src1_addr_q <= '0;
            src2_addr_q <= '0;
            dest1_q     <= '0;
            dest2_q     <= '0;
            src1_data_q <= '0;
            src2_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wfid_q      <= wfid_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            imm0_q      <= imm0_d;
            imm1_q      <= imm1_d;
            src1_addr_q <= src1_addr_d;
            src2_addr_q <= src2_addr_d;
            dest1_q     <= dest1_d;
            dest2_q     <= dest2_d;
            src1_data_q <= src1_data_d;
            src2_data_q <= src2_data_d;
            err_q       <= err_d;
        end
    end

    assign err_overrun     = err_q;
    assign exec_valid      = (state_q == VALID);
    assign exec_wfid       = wfid_q;
    assign exec_instr_pc   = pc_q;
    assign exec_opcode     = opcode_q;
    assign exec_imm_value0 = imm0_q;
    assign exec_dest1_addr = dest1_q;
    assign exec_dest2_addr = dest2_q;
    assign exec_src1_data  = src1_data_q;
    assign exec_src2_data  = src2_data_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: directed issues, RF model,
// monitors for exec handoff and RF read port.
module tb_alu_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_alu_select = 1'b0;
    logic [5:0]  issue_wfid = '0;
    logic [31:0] issue_instr_pc = '0;
    logic [31:0] issue_opcode = '0;
    logic [15:0] issue_imm_value0 = '0;
    logic [31:0] issue_imm_value1 = '0;
    logic [11:0] issue_src1_addr = '0;
    logic [11:0] issue_src2_addr = '0;
    logic [11:0] issue_dest1_addr = '0;
    logic [11:0] issue_dest2_addr = '0;
    logic        busy;
    logic        err_overrun;
    logic        rf_rd_en;
    logic        rf_rd_is_vgpr;
    logic [9:0]  rf_rd_addr;
    logic [31:0] rf_rd_data = '0;
    logic        exec_valid;
    logic        exec_ready = 1'b0;
    logic [5:0]  exec_wfid;
    logic [31:0] exec_instr_pc;
    logic [31:0] exec_opcode;
    logic [15:0] exec_imm_value0;
    logic [11:0] exec_dest1_addr;
    logic [11:0] exec_dest2_addr;
    logic [31:0] exec_src1_data;
    logic [31:0] exec_src2_data;

    alu_operand_fetch #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .issue_alu_select(issue_alu_select),
        .issue_wfid(issue_wfid),
        .issue_instr_pc(issue_instr_pc),
        .issue_opcode(issue_opcode),
        .issue_imm_value0(issue_imm_value0),
        .issue_imm_value1(issue_imm_value1),
        .issue_src1_addr(issue_src1_addr),
        .issue_src2_addr(issue_src2_addr),
        .issue_dest1_addr(issue_dest1_addr),
        .issue_dest2_addr(issue_dest2_addr),
        .busy(busy), .err_overrun(err_overrun),
        .rf_rd_en(rf_rd_en), .rf_rd_is_vgpr(rf_rd_is_vgpr),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .exec_valid(exec_valid), .exec_ready(exec_ready),
        .exec_wfid(exec_wfid), .exec_instr_pc(exec_instr_pc),
        .exec_opcode(exec_opcode), .exec_imm_value0(exec_imm_value0),
        .exec_dest1_addr(exec_dest1_addr), .exec_dest2_addr(exec_dest2_addr),
        .exec_src1_data(exec_src1_data), .exec_src2_data(exec_src2_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RF model: data one cycle after the strobe; poison when not read
    always @(posedge clk) begin
        if (rf_rd_en)
            rf_rd_data <= {rf_rd_is_vgpr ? 16'hAAAA : 16'h5555, 6'b0, rf_rd_addr};
        else
            rf_rd_data <= 32'h0BAD0BAD;
    end

    typedef struct {
        logic [5:0]  wfid;
        logic [31:0] pc;
        logic [31:0] op;
        logic [15:0] imm0;
        logic [31:0] imm1;
        logic [11:0] s1a, s2a, d1, d2;
        logic [31:0] s1, s2;
        logic        r1en, r1v;
        logic [9:0]  r1a;
        logic        r2en, r2v;
        logic [9:0]  r2a;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    typedef struct {
        int         c;
        logic       v;
        logic [9:0] a;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [191:0] act,
                       input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [173:0] pack_out();
        return {exec_wfid, exec_instr_pc, exec_opcode, exec_imm_value0,
                exec_dest1_addr, exec_dest2_addr, exec_src1_data, exec_src2_data};
    endfunction

    function automatic logic [173:0] pack_exp(input vec_t v);
        return {v.wfid, v.pc, v.op, v.imm0, v.d1, v.d2, v.s1, v.s2};
    endfunction

    function automatic vec_t mk(
        input logic [5:0] wfid, input logic [31:0] pc, input logic [31:0] op,
        input logic [15:0] imm0, input logic [31:0] imm1,
        input logic [11:0] s1a, input logic [11:0] s2a,
        input logic [11:0] d1, input logic [11:0] d2,
        input logic [31:0] s1, input logic [31:0] s2,
        input logic r1en, input logic r1v, input logic [9:0] r1a,
        input logic r2en, input logic r2v, input logic [9:0] r2a);
        vec_t v;
        v.wfid = wfid; v.pc = pc; v.op = op; v.imm0 = imm0; v.imm1 = imm1;
        v.s1a = s1a; v.s2a = s2a; v.d1 = d1; v.d2 = d2;
        v.s1 = s1; v.s2 = s2;
        v.r1en = r1en; v.r1v = r1v; v.r1a = r1a;
        v.r2en = r2en; v.r2v = r2v; v.r2a = r2a;
        return v;
    endfunction

    // exec-side monitor: latency, hold-stability and handoff contents
    logic [173:0] snap;
    bit           prev_v = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 0;
        end else begin
            if (exec_valid) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got exec_valid=1 expected none (cycle %0d)", cyc);
                    end else begin
                        chk("latency", 192'(cyc - exp_q[0].acc), 192'(3));
                    end
                    snap = pack_out();
                end else begin
                    chk("exec_hold", 192'(pack_out()), 192'(snap));
                end
                if (exec_ready && exp_q.size() > 0) begin
                    chk("exec_fields", 192'(pack_out()), 192'(pack_exp(exp_q[0].v)));
                    void'(exp_q.pop_front());
                end
            end
            prev_v = exec_valid && !exec_ready;
        end
    end

    // RF-port monitor: every cycle the read port must match the schedule
    logic       en_e, v_e;
    logic [9:0] a_e;
    always @(negedge clk) begin
        if (rst) begin
            en_e = 0; v_e = 0; a_e = '0;
            if (rd_q.size() > 0 && rd_q[0].c == cyc) begin
                en_e = 1; v_e = rd_q[0].v; a_e = rd_q[0].a;
                void'(rd_q.pop_front());
            end
            chk("rf_rd", 192'({rf_rd_en, rf_rd_is_vgpr, rf_rd_addr}),
                192'({en_e, v_e, a_e}));
        end
    end

    task automatic goto(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic issue(input vec_t v, input bit exp_acc);
        rd_t r;
        exp_t e;
        issue_alu_select = 1'b1;
        issue_wfid = v.wfid;
        issue_instr_pc = v.pc;
        issue_opcode = v.op;
        issue_imm_value0 = v.imm0;
        issue_imm_value1 = v.imm1;
        issue_src1_addr = v.s1a;
        issue_src2_addr = v.s2a;
        issue_dest1_addr = v.d1;
        issue_dest2_addr = v.d2;
        #1;
        chk("busy_at_select", 192'(busy), 192'(!exp_acc));
        if (exp_acc) begin
            e.v = v;
            e.acc = cyc + 1;
            exp_q.push_back(e);
            if (v.r1en) begin
                r.c = cyc + 1; r.v = v.r1v; r.a = v.r1a;
                rd_q.push_back(r);
            end
            if (v.r2en) begin
                r.c = cyc + 2; r.v = v.r2v; r.a = v.r2a;
                rd_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        issue_alu_select = 1'b0;
    endtask

    task automatic all_zero(input string name);
        chk(name, 192'({busy, err_overrun, rf_rd_en, rf_rd_is_vgpr, rf_rd_addr,
                        exec_valid, pack_out()}), 192'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    vec_t v1, v2, v3, v4, v5, v6, v7, v8;
    int   c;

    initial begin
        v1 = mk(6'h11, 32'h100, 32'hC0DE0001, 16'h1234, 32'h0,
                12'h805, 12'h403, 12'h010, 12'h020,
                32'hAAAA0005, 32'h55550003, 1, 1, 10'h005, 1, 0, 10'h003);
        v2 = mk(6'h3F, 32'h104, 32'hC0DE0002, 16'hFFFF, 32'hDEADBEEF,
                12'h0FF, 12'h0FF, 12'hFFF, 12'h800,
                32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 10'h0, 0, 0, 10'h0);
        v3 = mk(6'h01, 32'h108, 32'h00000003, 16'h0001, 32'h12345678,
                12'hBFF, 12'h5FF, 12'h001, 12'h002,
                32'hAAAA03FF, 32'h555501FF, 1, 1, 10'h3FF, 1, 0, 10'h1FF);
        v4 = mk(6'h22, 32'h10C, 32'h00000004, 16'h4444, 32'hCAFEF00D,
                12'hC01, 12'h2AA, 12'h044, 12'h045,
                32'hAAAA0001, 32'hCAFEF00D, 1, 1, 10'h001, 0, 0, 10'h0);
        v5 = mk(6'h23, 32'h110, 32'h00000005, 16'h5555, 32'h00000042,
                12'h3FF, 12'h9AB, 12'h055, 12'h056,
                32'h00000042, 32'hAAAA01AB, 0, 0, 10'h0, 1, 1, 10'h1AB);
        v6 = mk(6'h06, 32'h114, 32'h00000006, 16'h6666, 32'h0,
                12'h401, 12'h600, 12'h066, 12'h067,
                32'h55550001, 32'h55550000, 1, 0, 10'h001, 1, 0, 10'h000);
        v7 = mk(6'h07, 32'h999, 32'hFFFFFFFF, 16'h7777, 32'h77777777,
                12'h800, 12'h000, 12'h077, 12'h078,
                32'h0, 32'h0, 0, 0, 10'h0, 0, 0, 10'h0);
        v8 = mk(6'h08, 32'h118, 32'h00000008, 16'h8888, 32'h0,
                12'h808, 12'h408, 12'h088, 12'h089,
                32'hAAAA0008, 32'h55550008, 1, 1, 10'h008, 1, 0, 10'h008);

        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset_outputs");
        rst = 1'b1;
        @(posedge clk);
        #1;
        all_zero("post_release_outputs");

        // register fetch, VGPR then SGPR
        exec_ready = 1'b1;
        c = cyc;
        issue(v1, 1);
        goto(c + 8);

        // literal sources, no RF traffic
        c = cyc;
        issue(v2, 1);
        goto(c + 8);

        // backpressure: 5 cycles stalled in VALID
        exec_ready = 1'b0;
        c = cyc;
        issue(v3, 1);
        goto(c + 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 192'(exec_valid), 192'(1));
            chk("bp_busy", 192'(busy), 192'(1));
            @(posedge clk);
            #1;
        end
        exec_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_valid", 192'(exec_valid), 192'(0));
        chk("bp_idle_busy", 192'(busy), 192'(0));
        goto(cyc + 2);

        // back-to-back: new select on the VALID/ready cycle
        c = cyc;
        issue(v4, 1);
        goto(c + 4);
        issue(v5, 1);
        goto(c + 12);

        // overrun: select during RD2 is dropped
        chk("err_before", 192'(err_overrun), 192'(0));
        c = cyc;
        issue(v6, 1);
        goto(c + 2);
        issue(v7, 0);
        chk("err_set", 192'(err_overrun), 192'(1));
        goto(c + 10);
        chk("err_sticky", 192'(err_overrun), 192'(1));

        // asynchronous reset during CAP2
        c = cyc;
        issue(v8, 1);
        goto(c + 3);
        rst = 1'b0;
        #1;
        all_zero("async_reset_outputs");
        exp_q.delete();
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        c = cyc;
        goto(c + 12);
        chk("no_valid_after_reset", 192'(exec_valid), 192'(0));
        chk("queues_empty", 192'(exp_q.size() + rd_q.size()), 192'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
